// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, issues one instruction-memory request at a time
// and hands {instruction, pc, pc+4} to decode through a registered IF/ID slot.
module instruction_fetch #(
   parameter int                         ADDRESS_WIDTH = 32,
   parameter int                         DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0
) (
   input  logic                      clock,
   input  logic                      reset_n,
   output logic                      imem_req_valid,
   input  logic                      imem_req_ready,
   output logic [ADDRESS_WIDTH-1:0]  imem_addr,
   input  logic                      imem_resp_valid,
   input  logic [DATA_WIDTH-1:0]     imem_resp_data,
   input  logic                      stall,
   input  logic                      redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0]  redirect_target,
   output logic                      id_valid,
   output logic [DATA_WIDTH-1:0]     id_instruction,
   output logic [ADDRESS_WIDTH-1:0]  id_pc,
   output logic [ADDRESS_WIDTH-1:0]  id_pc_plus4
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]    instruction;
      logic [ADDRESS_WIDTH-1:0] pc;
      logic [ADDRESS_WIDTH-1:0] pc_plus4;
   } slot_t;

   state_t                   state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] pc, pc_plus4, target_aligned;
   slot_t                    slot, hold;
   logic                     accept, slot_free;
   logic                     load_resp, hold_capture, hold_release;
   logic                     unused_target_lsbs;

   assign pc_plus4           = pc + ADDRESS_WIDTH'(4);
   assign target_aligned     = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
   assign unused_target_lsbs = ^redirect_target[1:0];
   assign accept             = imem_req_valid && imem_req_ready;
   assign slot_free          = !id_valid || !stall;
   assign imem_addr          = pc;

   assign id_instruction = slot.instruction;
   assign id_pc          = slot.pc;
   assign id_pc_plus4    = slot.pc_plus4;

   always_ff @(posedge clock) begin
      if (!reset_n) state <= S_REQ;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         case (state)
            S_REQ:  state_nxt = accept ? S_DROP : S_REQ;
            S_WAIT: state_nxt = imem_resp_valid ? S_REQ : S_DROP;
            S_HOLD: state_nxt = S_REQ;
            // a response landing with the redirect closes the old request
            S_DROP: state_nxt = imem_resp_valid ? S_REQ : S_DROP;
            default: state_nxt = S_REQ;
         endcase
      end else begin
         case (state)
            S_REQ:  if (accept) state_nxt = S_WAIT;
            S_WAIT: if (imem_resp_valid) state_nxt = slot_free ? S_REQ : S_HOLD;
            S_HOLD: if (!stall) state_nxt = S_REQ;
            S_DROP: if (imem_resp_valid) state_nxt = S_REQ;
            default: state_nxt = S_REQ;
         endcase
      end
   end

   always_comb begin
      imem_req_valid = reset_n && (state == S_REQ);
      load_resp      = !redirect_valid && (state == S_WAIT) && imem_resp_valid && slot_free;
      hold_capture   = !redirect_valid && (state == S_WAIT) && imem_resp_valid && !slot_free;
      hold_release   = !redirect_valid && (state == S_HOLD) && !stall;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc       <= RESET_VECTOR;
         slot     <= '0;
         hold     <= '0;
         id_valid <= 1'b0;
      end else if (redirect_valid) begin
         pc       <= target_aligned;
         id_valid <= 1'b0;
      end else if (load_resp) begin
         slot     <= '{instruction: imem_resp_data, pc: pc, pc_plus4: pc_plus4};
         id_valid <= 1'b1;
         pc       <= pc_plus4;
      end else if (hold_capture) begin
         hold     <= '{instruction: imem_resp_data, pc: pc, pc_plus4: pc_plus4};
         pc       <= pc_plus4;
      end else if (hold_release) begin
         slot     <= hold;
         id_valid <= 1'b1;
      end else if (id_valid && !stall) begin
         id_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run checked
// against an instruction-stream model (sequential PCs, redirects restart the stream).
module tb_instruction_fetch;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req_ready = 1'b0;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;

   logic        imem_req_valid, id_valid;
   logic [31:0] imem_addr, id_instruction, id_pc, id_pc_plus4;
   logic        w_req_valid, w_id_valid;
   logic [31:0] w_addr, w_id_instruction, w_id_pc, w_id_pc_plus4;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   instruction_fetch u_dut (
      .clock(clock), .reset_n(reset_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .id_valid(id_valid), .id_instruction(id_instruction), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
   );

   instruction_fetch #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
      .clock(clock), .reset_n(reset_n),
      .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .id_valid(w_id_valid), .id_instruction(w_id_instruction), .id_pc(w_id_pc), .id_pc_plus4(w_id_pc_plus4)
   );

   // instruction memory contents: a distinct word per address
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic respond(input logic [31:0] data);
      imem_resp_valid = 1'b1;
      imem_resp_data  = data;
      tick();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; imem_req_ready = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
      tick(); tick();
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      checks++; if ({id_valid, id_instruction, id_pc, id_pc_plus4} !== '0) begin errors++;
         $display("FAIL reset_slot: got v=%b i=%h pc=%h p4=%h want all 0", id_valid, id_instruction, id_pc, id_pc_plus4); end
      reset_n = 1'b1; #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++;
         $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_addr); end
   endtask

   task automatic test_free_run();
      logic [31:0] exp;
      exp = 32'h0;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_req_valid !== 1'b1 || imem_addr !== exp) begin errors++;
            $display("FAIL fr_req%0d: got v=%b a=%h want v=1 a=%h", i, imem_req_valid, imem_addr, exp); end
         tick();
         checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin errors++;
            $display("FAIL fr_wait%0d: got req=%b idv=%b want 0 0", i, imem_req_valid, id_valid); end
         respond(mem(exp));
         checks++; if (id_valid !== 1'b1 || id_pc !== exp || id_pc_plus4 !== exp + 32'd4 || id_instruction !== mem(exp)) begin errors++;
            $display("FAIL fr_slot%0d: got v=%b pc=%h p4=%h i=%h want pc=%h i=%h", i, id_valid, id_pc, id_pc_plus4, id_instruction, exp, mem(exp)); end
         exp += 32'd4;
      end
   endtask

   task automatic test_hold();
      tick();
      respond(mem(32'hC));
      checks++; if (id_pc !== 32'hC || id_valid !== 1'b1) begin errors++; $display("FAIL hold_setup: got pc=%h v=%b want C 1", id_pc, id_valid); end
      stall = 1'b1;
      tick();
      respond(32'h8C22_0004);
      for (int j = 0; j < 3; j++) begin
         checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'hC || id_instruction !== mem(32'hC)) begin errors++;
            $display("FAIL hold_stalled%0d: got req=%b v=%b pc=%h want req=0 v=1 pc=C", j, imem_req_valid, id_valid, id_pc); end
         tick();
      end
      stall = 1'b0;
      tick();
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_instruction !== 32'h8C22_0004 || id_pc_plus4 !== 32'h14) begin errors++;
         $display("FAIL hold_release: got v=%b pc=%h i=%h p4=%h want 1 10 8c220004 14", id_valid, id_pc, id_instruction, id_pc_plus4); end
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h14) begin errors++;
         $display("FAIL hold_next_req: got v=%b a=%h want 1 14", imem_req_valid, imem_addr); end
   endtask

   task automatic test_redirect_wait();
      tick();
      redirect_valid = 1'b1; redirect_target = 32'h403;
      tick();
      redirect_valid = 1'b0;
      checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== 32'h400) begin errors++;
         $display("FAIL rdw_drop: got v=%b req=%b a=%h want 0 0 400", id_valid, imem_req_valid, imem_addr); end
      tick();
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_drop_wait: got req=%b want 0", imem_req_valid); end
      respond(mem(32'h14));
      checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h400) begin errors++;
         $display("FAIL rdw_discard: got v=%b req=%b a=%h want 0 1 400", id_valid, imem_req_valid, imem_addr); end
      tick();
      respond(mem(32'h400));
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h400 || id_instruction !== mem(32'h400)) begin errors++;
         $display("FAIL rdw_target: got v=%b pc=%h i=%h want 1 400 %h", id_valid, id_pc, id_instruction, mem(32'h400)); end
   endtask

   task automatic test_redirect_resp();
      tick();
      redirect_valid = 1'b1; redirect_target = 32'h200;
      respond(mem(32'h404));
      redirect_valid = 1'b0;
      checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin errors++;
         $display("FAIL rdr_nodrop: got v=%b req=%b a=%h want 0 1 200", id_valid, imem_req_valid, imem_addr); end
      tick();
      respond(mem(32'h200));
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instruction !== mem(32'h200)) begin errors++;
         $display("FAIL rdr_target: got v=%b pc=%h i=%h want 1 200 %h", id_valid, id_pc, id_instruction, mem(32'h200)); end
   endtask

   task automatic test_req_backpressure();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h204) begin errors++;
            $display("FAIL bp_hold%0d: got v=%b a=%h want 1 204", i, imem_req_valid, imem_addr); end
         tick();
      end
      redirect_valid = 1'b1; redirect_target = 32'h301;
      tick();
      redirect_valid = 1'b0;
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h300) begin errors++;
         $display("FAIL bp_redirect: got v=%b a=%h want 1 300", imem_req_valid, imem_addr); end
      imem_req_ready = 1'b1;
      tick();
      respond(mem(32'h300));
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_instruction !== mem(32'h300)) begin errors++;
         $display("FAIL bp_fetch: got v=%b pc=%h i=%h want 1 300 %h", id_valid, id_pc, id_instruction, mem(32'h300)); end
   endtask

   task automatic test_wrap();
      reset_n = 1'b0; imem_req_ready = 1'b1; stall = 1'b0;
      tick(); tick();
      reset_n = 1'b1; #1;
      checks++; if (w_req_valid !== 1'b1 || w_addr !== 32'hFFFF_FFFC || w_id_valid !== 1'b0) begin errors++;
         $display("FAIL wrap_reset: got v=%b a=%h idv=%b want 1 fffffffc 0", w_req_valid, w_addr, w_id_valid); end
      tick();
      respond(mem(32'hFFFF_FFFC));
      checks++; if (w_id_valid !== 1'b1 || w_id_pc !== 32'hFFFF_FFFC || w_id_pc_plus4 !== 32'h0 || w_id_instruction !== mem(32'hFFFF_FFFC)) begin errors++;
         $display("FAIL wrap_slot: got v=%b pc=%h p4=%h i=%h want 1 fffffffc 0", w_id_valid, w_id_pc, w_id_pc_plus4, w_id_instruction); end
      checks++; if (w_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got %h want 0", w_addr); end
      tick();
      reset_n = 1'b0;
      respond(mem(32'h0));
      checks++; if (w_req_valid !== 1'b0 || w_id_valid !== 1'b0 || w_id_pc !== 32'h0) begin errors++;
         $display("FAIL wrap_midreset: got req=%b v=%b pc=%h want 0 0 0", w_req_valid, w_id_valid, w_id_pc); end
      reset_n = 1'b1; #1;
      checks++; if (w_req_valid !== 1'b1 || w_addr !== 32'hFFFF_FFFC || w_id_valid !== 1'b0) begin errors++;
         $display("FAIL wrap_restart: got v=%b a=%h idv=%b want 1 fffffffc 0", w_req_valid, w_addr, w_id_valid); end
      tick();
      respond(mem(32'hFFFF_FFFC));
      checks++; if (w_id_valid !== 1'b1 || w_id_pc !== 32'hFFFF_FFFC) begin errors++;
         $display("FAIL wrap_refetch: got v=%b pc=%h want 1 fffffffc", w_id_valid, w_id_pc); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, resp_addr, prev_addr;
      bit          outstanding, prev_hold;
      int          cnt, consumed;
      reset_n = 1'b0; imem_req_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0; imem_resp_valid = 1'b0;
      tick(); tick();
      reset_n = 1'b1; #1;
      exp_pc = 32'h0; outstanding = 0; prev_hold = 0; cnt = 0; consumed = 0;
      resp_addr = '0; prev_addr = '0;
      for (int c = 0; c < 3000; c++) begin
         if (outstanding && cnt == 0) begin
            imem_resp_valid = 1'b1; imem_resp_data = mem(resp_addr); outstanding = 0;
         end else begin
            imem_resp_valid = 1'b0; imem_resp_data = $urandom;
            if (outstanding) cnt--;
         end
         stall           = ($urandom_range(0, 3) == 0);
         imem_req_ready  = ($urandom_range(0, 2) != 0);
         redirect_valid  = ($urandom_range(0, 39) == 0);
         redirect_target = $urandom_range(0, 4095);
         if (prev_hold) begin
            checks++; if (imem_addr !== prev_addr) begin errors++;
               $display("FAIL rnd_addr_stable c=%0d: got %h want %h", c, imem_addr, prev_addr); end
         end
         prev_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
         prev_addr = imem_addr;
         if (imem_req_valid && imem_req_ready) begin
            checks++; if (outstanding || imem_resp_valid) begin errors++;
               $display("FAIL rnd_one_outstanding c=%0d: got second request a=%h want none", c, imem_addr); end
            outstanding = 1; resp_addr = imem_addr; cnt = $urandom_range(0, 3);
         end
         if (id_valid && !stall && !redirect_valid) begin
            checks++;
            if (id_pc !== exp_pc || id_pc_plus4 !== exp_pc + 32'd4 || id_instruction !== mem(exp_pc)) begin errors++;
               $display("FAIL rnd_stream c=%0d: got pc=%h p4=%h i=%h want pc=%h i=%h", c, id_pc, id_pc_plus4, id_instruction, exp_pc, mem(exp_pc)); end
            exp_pc += 32'd4;
            consumed++;
         end
         if (redirect_valid) exp_pc = redirect_target & ~32'h3;
         tick();
      end
      imem_resp_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
      checks++; if (consumed < 150) begin errors++; $display("FAIL rnd_progress: got %0d instructions want >= 150", consumed); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_free_run();
      test_hold();
      test_redirect_wait();
      test_redirect_resp();
      test_req_backpressure();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the MIPS pipeline, directly upstream of decode, which feeds the RegisterFile read addresses and SignExtend.
- Holds the PC and issues one instruction-memory request at a time over a valid/ready request channel.
- Delivers {instruction, pc, pc+4} to decode through a registered IF/ID slot, with stall, redirect (branch/jump flush) and discard of stale responses.

Parameters:
- ADDRESS_WIDTH, 32, PC and memory address width.
- DATA_WIDTH, 32, instruction width.
- RESET_VECTOR, 0, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  ADDRESS_WIDTH  request address, equal to the PC.
- imem_resp_valid  input  1  response data valid, 1 cycle.
- imem_resp_data  input  DATA_WIDTH  instruction word.
- stall  input  1  decode cannot take the IF/ID slot this cycle.
- redirect_valid  input  1  branch/jump taken; flush the pipeline.
- redirect_target  input  ADDRESS_WIDTH  new PC; bits [1:0] are ignored and forced to 0.
- id_valid  output  1  IF/ID slot holds a valid instruction.
- id_instruction  output  DATA_WIDTH  fetched instruction.
- id_pc  output  ADDRESS_WIDTH  address of id_instruction.
- id_pc_plus4  output  ADDRESS_WIDTH  id_pc + 4.

Behaviour:
- Reset (reset_n low at a rising edge):
  - pc = RESET_VECTOR; state = REQ.
  - id_valid, id_instruction, id_pc, id_pc_plus4 and the hold register are cleared to 0.
  - imem_req_valid is forced to 0 while reset_n is low.
  - Reset mid-operation abandons any in-flight request. Its response is ignored only if it arrives while reset_n is low.
- Handshakes:
  - The request transfers when imem_req_valid && imem_req_ready.
  - imem_addr holds stable while valid and not yet ready, except on redirect.
  - Decode consumes the slot when id_valid && !stall.
- imem_req_valid = 1 only in state REQ. imem_addr = pc at all times.
- PC arithmetic: pc+4 is computed modulo 2^ADDRESS_WIDTH, so 0xFFFFFFFC wraps to 0x00000000.
- FSM states: REQ, WAIT, HOLD, DROP.
  - REQ: on accept, go to WAIT.
  - WAIT, on response:
    - Slot free (!id_valid, or the slot is being consumed this cycle): load the slot with {resp_data, pc, pc+4}, set id_valid = 1, pc <= pc+4, go to REQ.
    - Slot occupied and stalled: capture the response in the hold register, pc <= pc+4, go to HOLD.
  - HOLD: when !stall, move the hold register into the slot (id_valid stays 1), go to REQ.
  - DROP: wait for the response, discard it, go to REQ.
- Redirect (highest priority, any state):
  - id_valid <= 0 and the hold register is invalidated.
  - pc <= {redirect_target[ADDRESS_WIDTH-1:2], 2'b00}.
  - REQ with the request accepted in the same cycle: go to DROP.
  - REQ not accepted: stay in REQ; the next cycle requests the target.
  - WAIT with the response in the same cycle: discard it, go to REQ.
  - WAIT without a response: go to DROP.
  - HOLD: go to REQ.
  - DROP: stay in DROP with the new pc.
- id_valid clears on consumption when no new load occurs that cycle.
- Latency and throughput:
  - Request accepted at edge t, response at cycle t+k (k>=1).
  - id_valid rises at the edge ending the response cycle.
  - Peak throughput is 1 instruction per 2 cycles.
- At most one request is outstanding. The block never drops or duplicates an instruction unless a redirect occurs.
- Responses arriving in REQ (protocol violation) are ignored.

Test Plan:
- Reset then free-run, ready=1, 1-cycle response, stall=0 -> addresses 0x0, 0x4, 0x8. id_pc matches each address and id_pc_plus4 = id_pc+4. id_valid pulses every 2nd cycle with the correct data.
- Response 0x8C220004 at pc 0x10 while the slot holds pc 0xC and stall=1 for 3 cycles -> state HOLD, no new request, slot stays 0xC. After stall drops: slot = 0x10/0x8C220004, then a request for 0x14.
- Redirect to 0x403 in WAIT before the response -> id_valid=0 next cycle, state DROP. The late response is discarded; the next request address is 0x400 and the next id_pc is 0x400.
- Redirect in the same cycle as the response -> the response is discarded and not loaded. The next request is the target with no DROP.
- imem_req_ready=0 for 4 cycles -> imem_req_valid held 1, imem_addr stable. Redirect during the stall changes the address to the target.
- RESET_VECTOR=0xFFFFFFFC -> the second fetch address is 0x00000000 and id_pc_plus4 = 0. A reset_n pulse in WAIT returns to REQ with pc=RESET_VECTOR and id_valid=0.
